// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and sizing helpers used by the top level.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk operand still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// Combinational unsigned comparator for one CHUNK-bit slice of the operands.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per clock from the MSB
// end, optionally stopping at the first differing chunk.
module seq_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   A,
  input  logic [WIDTH-1:0]                   B,
  input  logic                               signed_mode,
  output logic                               busy,
  output logic                               done,
  output logic                               A_gt_B,
  output logic                               A_lt_B,
  output logic                               A_eq_B,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDXW-1:0]   idx;
  logic [CW-1:0]     cnt;
  logic              decided, gt_q, lt_q;
  logic              accept, finish, exit_now, decided_next;
  logic [CHUNK-1:0]  a_ch [NCHUNK];
  logic [CHUNK-1:0]  b_ch [NCHUNK];
  logic              c_gt, c_lt, c_eq;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
    assign a_ch[i] = a_q[i*CHUNK +: CHUNK];
    assign b_ch[i] = b_q[i*CHUNK +: CHUNK];
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_ch[idx]),
    .b  (b_ch[idx]),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  assign decided_next = decided | ~c_eq;
  assign exit_now     = (EARLY_EXIT && decided_next) || (idx == '0);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = COMPARE;
        end else begin
          state_next = IDLE;
        end
      end
      COMPARE: begin
        if (exit_now) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

  // Operand capture; the MSB flip maps two's-complement onto offset binary
  // so the chunk scan stays purely unsigned.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= signed_mode ? (A ^ MSB_MASK) : A;
      b_q <= signed_mode ? (B ^ MSB_MASK) : B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      A_gt_B  <= 1'b0;
      A_lt_B  <= 1'b0;
      A_eq_B  <= 1'b0;
      cycles  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx     <= IDXW'(NCHUNK - 1);
        cnt     <= '0;
        decided <= 1'b0;
        gt_q    <= 1'b0;
        lt_q    <= 1'b0;
      end else if (state == COMPARE) begin
        cnt <= cnt + CW'(1);
        if (!decided && !c_eq) begin
          gt_q    <= c_gt;
          lt_q    <= c_lt;
          decided <= 1'b1;
        end
        if (!exit_now) idx <= idx - IDXW'(1);
      end
      // Published result only moves on completion, so it holds across the
      // following compare until that one finishes.
      if (finish) begin
        A_gt_B <= decided ? gt_q : c_gt;
        A_lt_B <= decided ? lt_q : c_lt;
        A_eq_B <= ~decided_next;
        cycles <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: default, full-scan and small
// exhaustive configurations.
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, sm = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, gt, lt, eq;
  logic [2:0]  cyc;

  logic        f_start = 1'b0, f_sm = 1'b0;
  logic [15:0] f_a = '0, f_b = '0;
  logic        f_busy, f_done, f_gt, f_lt, f_eq;
  logic [2:0]  f_cyc;

  logic        s_start = 1'b0, s_sm = 1'b0;
  logic [3:0]  s_a = '0, s_b = '0;
  logic        s_busy, s_done, s_gt, s_lt, s_eq;
  logic [1:0]  s_cyc;

  int checks = 0;
  int errors = 0;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .signed_mode(sm),
    .busy(busy), .done(done), .A_gt_B(gt), .A_lt_B(lt), .A_eq_B(eq), .cycles(cyc));

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(f_start), .A(f_a), .B(f_b), .signed_mode(f_sm),
    .busy(f_busy), .done(f_done), .A_gt_B(f_gt), .A_lt_B(f_lt), .A_eq_B(f_eq), .cycles(f_cyc));

  seq_magnitude_comparator #(.WIDTH(4), .CHUNK(2), .EARLY_EXIT(1'b1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .A(s_a), .B(s_b), .signed_mode(s_sm),
    .busy(s_busy), .done(s_done), .A_gt_B(s_gt), .A_lt_B(s_lt), .A_eq_B(s_eq), .cycles(s_cyc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [15:0] xa, input logic [15:0] xb, input logic xs);
    @(negedge clk);
    a = xa; b = xb; sm = xs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; lat counts edges to done.
  task automatic expect_res(input string tag, input logic [2:0] flags,
                            input int k, input int exp_lat);
    int lat;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " flags"}, 32'({gt, lt, eq}), 32'(flags));
    check({tag, " cycles"}, 32'(cyc), 32'(k));
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat, va, vb, ek;
    logic [3:0] xa4, xb4;
    logic eg, el, ee;

    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, done, gt, lt, eq, cyc}), 32'd0);
    check("reset small outputs", 32'({s_busy, s_done, s_gt, s_lt, s_eq, s_cyc}), 32'd0);
    rst = 1'b0;

    go(16'h0003, 16'h0001, 1'b0);
    expect_res("first gt", 3'b100, 4, 4);

    go(16'h1234, 16'h1234, 1'b0);
    expect_res("equal", 3'b001, 4, 4);
    @(negedge clk);
    check("equal hold idle", 32'({busy, done, gt, lt, eq}), 32'b00001);
    go(16'h8000, 16'h7FFF, 1'b0);
    check("hold while busy", 32'({busy, gt, lt, eq}), 32'b1001);
    expect_res("unsigned msb", 3'b100, 1, 1);

    go(16'h8000, 16'h7FFF, 1'b1);
    expect_res("signed msb", 3'b010, 1, 1);

    go(16'h12F4, 16'h12E4, 1'b0);
    expect_res("early exit", 3'b100, 3, 3);

    @(negedge clk);
    f_a = 16'h12F4; f_b = 16'h12E4; f_sm = 1'b0; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    lat = 0;
    while (!f_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("full scan result", 32'({f_done, f_gt, f_lt, f_eq, f_cyc}), {27'd0, 1'b1, 3'b100, 3'd4});
    check("full scan latency", 32'(lat), 32'd4);

    // A second start while busy must be ignored.
    go(16'h0001, 16'h0002, 1'b0);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_res("ignore busy start", 3'b010, 4, 3);

    // start held high through DONE: next compare begins with no gap.
    @(negedge clk);
    a = 16'h5000; b = 16'h4000; sm = 1'b0; start = 1'b1;
    @(negedge clk);
    check("b2b first busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b first done", 32'({done, gt, lt, eq, cyc}), {27'd0, 1'b1, 3'b100, 3'd1});
    a = 16'h1111; b = 16'h1111;
    @(negedge clk);
    check("b2b no gap", 32'({busy, done}), 32'b10);
    check("b2b hold", 32'({gt, lt, eq}), 32'b100);
    start = 1'b0;
    expect_res("b2b second", 3'b001, 4, 4);

    // Asynchronous reset in the middle of a compare.
    go(16'h1234, 16'h1235, 1'b0);
    #2 rst = 1'b1;
    #1 check("async reset", 32'({busy, done, gt, lt, eq, cyc}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after reset idle", 32'({busy, done, gt, lt, eq}), 32'd0);
    go(16'h0003, 16'h0001, 1'b0);
    expect_res("post reset gt", 3'b100, 4, 4);

    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          xa4 = 4'(x); xb4 = 4'(y);
          @(negedge clk);
          s_a = xa4; s_b = xb4; s_sm = 1'(s); s_start = 1'b1;
          @(negedge clk);
          s_start = 1'b0;
          lat = 0;
          while (!s_done && lat < 10) begin
            @(negedge clk);
            lat++;
          end
          va = (s == 1 && x >= 8) ? x - 16 : x;
          vb = (s == 1 && y >= 8) ? y - 16 : y;
          eg = (va > vb);
          el = (va < vb);
          ee = (va == vb);
          ek = (xa4[3:2] != xb4[3:2]) ? 1 : 2;
          check($sformatf("exhaustive s%0d a%0h b%0h", s, x, y),
                32'({s_done, s_gt, s_lt, s_eq, s_cyc}),
                {26'd0, 1'b1, eg, el, ee, 2'(ek)});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
